// File: rtl/output_packer_pkg.sv
// Shared types for the output packer: element coordinates and the packed
// word that travels through the output FIFO.
package output_packer_pkg;

  localparam int unsigned PKG_DATA_W      = 16;
  localparam int unsigned PKG_FM_WIDTH    = 1024;
  localparam int unsigned PKG_FM_HEIGHT   = 1024;
  localparam int unsigned PKG_NB_CHANNELS = 64;
  localparam int unsigned PKG_PACK_FACTOR = 2;

  localparam int unsigned PKG_X_W  = $clog2(PKG_FM_WIDTH);
  localparam int unsigned PKG_Y_W  = $clog2(PKG_FM_HEIGHT);
  localparam int unsigned PKG_CH_W = $clog2(PKG_NB_CHANNELS);

  typedef struct packed {
    logic [PKG_X_W-1:0]  x;
    logic [PKG_Y_W-1:0]  y;
    logic [PKG_CH_W-1:0] ch;
  } coord_t;

  typedef struct packed {
    logic [PKG_PACK_FACTOR*PKG_DATA_W-1:0] data;
    logic [PKG_PACK_FACTOR-1:0]            mask;
    coord_t                                coord;
  } pack_word_t;

  // Negative elements clamp to zero; width is preserved.
  function automatic logic [PKG_DATA_W-1:0] relu_clamp(input logic [PKG_DATA_W-1:0] v);
    return v[PKG_DATA_W-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/output_fifo.sv
// Synchronous FIFO of packed words. The head is presented combinationally
// from the storage array and forced to zero while empty, so the visible
// outputs are clean after reset or clear without resetting the array.
module output_fifo
  import output_packer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       arst_n_in,
  input  logic       clear,
  input  logic       push,
  input  pack_word_t push_word,
  input  logic       pop,
  output pack_word_t head_word,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  pack_word_t      mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);

  assign head_word = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Read and write pointers; an extra wrap bit distinguishes full from empty.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_word;
  end

endmodule

// File: rtl/output_packer.sv
// Packs the one-element-per-cycle result stream into PACK_FACTOR-wide words
// and buffers them for the host. The producer cannot be stalled, so a word
// arriving at a full FIFO is dropped and recorded in the sticky overflow flag.
module output_packer
  import output_packer_pkg::*;
#(
  parameter int unsigned IO_DATA_WIDTH      = PKG_DATA_W,
  parameter int unsigned FEATURE_MAP_WIDTH  = PKG_FM_WIDTH,
  parameter int unsigned FEATURE_MAP_HEIGHT = PKG_FM_HEIGHT,
  parameter int unsigned OUTPUT_NB_CHANNELS = PKG_NB_CHANNELS,
  parameter int unsigned PACK_FACTOR        = PKG_PACK_FACTOR,
  parameter int unsigned FIFO_DEPTH         = 8,
  parameter bit          RELU_EN            = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   arst_n_in,
  input  logic                                   start,
  input  logic                                   flush,
  input  logic [IO_DATA_WIDTH-1:0]               in_data,
  input  logic                                   in_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]   in_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]  in_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]  in_ch,
  output logic [PACK_FACTOR*IO_DATA_WIDTH-1:0]   pack_data,
  output logic [PACK_FACTOR-1:0]                 pack_mask,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]   pack_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]  pack_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]  pack_ch,
  output logic                                   pack_valid,
  input  logic                                   pack_ready,
  output logic                                   overflow,
  output logic [31:0]                            word_count
);

  // The packed-word struct is sized by the package constants; the top-level
  // parameters must keep their default values for the two to agree.
  localparam int unsigned LANE_W = $clog2(PACK_FACTOR);

  logic [LANE_W-1:0]        lane;
  logic [IO_DATA_WIDTH-1:0] lanes [PACK_FACTOR];
  coord_t                   coord_q;
  coord_t                   in_coord;
  logic [IO_DATA_WIDTH-1:0] elem;
  logic                     complete;
  logic                     flush_push;
  logic                     push_req;
  logic                     pop;
  logic                     push_ok;
  logic                     drop;
  logic                     fifo_full;
  logic                     fifo_empty;
  pack_word_t               push_word;
  pack_word_t               head_word;

  assign in_coord = '{x: in_x, y: in_y, ch: in_ch};
  assign elem     = RELU_EN ? relu_clamp(in_data) : in_data;

  // start wins over everything, so it masks both push sources.
  assign complete   = !start && in_valid && (lane == LANE_W'(PACK_FACTOR - 1));
  assign flush_push = !start && flush && !complete && ((lane != '0) || in_valid);
  assign push_req   = complete || flush_push;

  assign pop     = !fifo_empty && pack_ready;
  assign push_ok = push_req && (!fifo_full || pop);
  assign drop    = push_req && fifo_full && !pop;

  // Word being pushed: held lanes plus this cycle's element; unfilled lanes zero.
  always_comb begin
    push_word       = '0;
    push_word.coord = (lane == '0) ? in_coord : coord_q;
    for (int i = 0; i < int'(PACK_FACTOR); i++) begin
      if (in_valid && (LANE_W'(i) == lane)) begin
        push_word.data[i*IO_DATA_WIDTH +: IO_DATA_WIDTH] = elem;
        push_word.mask[i] = 1'b1;
      end else if (LANE_W'(i) < lane) begin
        push_word.data[i*IO_DATA_WIDTH +: IO_DATA_WIDTH] = lanes[i];
        push_word.mask[i] = 1'b1;
      end
    end
  end

  // Assembly register: lane counter, lane data and lane-0 coordinates.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      lane    <= '0;
      coord_q <= '0;
      for (int i = 0; i < int'(PACK_FACTOR); i++) lanes[i] <= '0;
    end else if (start) begin
      lane <= '0;
    end else begin
      if (in_valid) begin
        lanes[lane] <= elem;
        if (lane == '0) coord_q <= in_coord;
      end
      if (push_req)      lane <= '0;
      else if (in_valid) lane <= lane + 1'b1;
    end
  end

  // Sticky overflow flag and count of words accepted into the FIFO.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      overflow   <= 1'b0;
      word_count <= '0;
    end else if (start) begin
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      if (drop)    overflow   <= 1'b1;
      if (push_ok) word_count <= word_count + 32'd1;
    end
  end

  output_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .clear     (start),
    .push      (push_req),
    .push_word (push_word),
    .pop       (pop),
    .head_word (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pack_valid = !fifo_empty;
  assign pack_data  = head_word.data;
  assign pack_mask  = head_word.mask;
  assign pack_x     = head_word.coord.x;
  assign pack_y     = head_word.coord.y;
  assign pack_ch    = head_word.coord.ch;

endmodule

// File: tb/tb_output_packer.sv
// Directed bench for output_packer. A second instance with ReLU enabled
// shares the input stimulus and is only inspected in the ReLU scenario.
module tb_output_packer;

  logic        clk = 1'b0;
  logic        arst_n_in = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [9:0]  in_x = '0;
  logic [9:0]  in_y = '0;
  logic [5:0]  in_ch = '0;
  logic        pack_ready = 1'b0;

  logic [31:0] pack_data;
  logic [1:0]  pack_mask;
  logic [9:0]  pack_x;
  logic [9:0]  pack_y;
  logic [5:0]  pack_ch;
  logic        pack_valid;
  logic        overflow;
  logic [31:0] word_count;

  logic [31:0] r_data;
  logic [1:0]  r_mask;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [5:0]  r_ch;
  logic        r_valid;
  logic        r_overflow;
  logic [31:0] r_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_packer #(.RELU_EN(1'b0)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .pack_data(pack_data), .pack_mask(pack_mask), .pack_x(pack_x), .pack_y(pack_y),
    .pack_ch(pack_ch), .pack_valid(pack_valid), .pack_ready(pack_ready),
    .overflow(overflow), .word_count(word_count)
  );

  output_packer #(.RELU_EN(1'b1)) dut_relu (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .pack_data(r_data), .pack_mask(r_mask), .pack_x(r_x), .pack_y(r_y),
    .pack_ch(r_ch), .pack_valid(r_valid), .pack_ready(pack_ready),
    .overflow(r_overflow), .word_count(r_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [9:0] x);
    in_data  = d;
    in_x     = x;
    in_y     = 10'd0;
    in_ch    = 6'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2 arst_n_in = 1'b0;
    #1;
    checks++; if (pack_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pack_valid); end
    checks++; if (pack_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", pack_data); end
    checks++; if (pack_mask !== 2'b00) begin errors++; $display("FAIL reset_mask: got %b expected 00", pack_mask); end
    checks++; if ({pack_x, pack_y, pack_ch} !== 26'h0) begin errors++; $display("FAIL reset_coords: got %h expected 0", {pack_x, pack_y, pack_ch}); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (word_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", word_count); end
    tick();
    arst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    pack_ready = 1'b1;
    send(16'd1, 10'd0);
    checks++; if (pack_valid !== 1'b0) begin errors++; $display("FAIL basic_half_valid: got %b expected 0", pack_valid); end
    send(16'd2, 10'd1);
    checks++; if (pack_valid !== 1'b1) begin errors++; $display("FAIL basic_w0_valid: got %b expected 1", pack_valid); end
    checks++; if (pack_data !== 32'h0002_0001) begin errors++; $display("FAIL basic_w0_data: got %h expected 00020001", pack_data); end
    checks++; if (pack_mask !== 2'b11) begin errors++; $display("FAIL basic_w0_mask: got %b expected 11", pack_mask); end
    checks++; if ({pack_x, pack_y, pack_ch} !== {10'd0, 10'd0, 6'd5}) begin errors++; $display("FAIL basic_w0_coords: got x=%0d y=%0d ch=%0d expected 0 0 5", pack_x, pack_y, pack_ch); end
    send(16'd3, 10'd2);
    checks++; if (pack_valid !== 1'b0) begin errors++; $display("FAIL basic_popped: got %b expected 0", pack_valid); end
    send(16'd4, 10'd3);
    checks++; if (pack_data !== 32'h0004_0003) begin errors++; $display("FAIL basic_w1_data: got %h expected 00040003", pack_data); end
    checks++; if (pack_x !== 10'd2) begin errors++; $display("FAIL basic_w1_x: got %0d expected 2", pack_x); end
    tick();
    checks++; if (word_count !== 32'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", word_count); end
  endtask

  task automatic test_relu();
    pulse_start();
    pack_ready = 1'b1;
    send(16'hFFF9, 10'd0);
    send(16'd9, 10'd1);
    checks++; if (r_data !== 32'h0009_0000) begin errors++; $display("FAIL relu_data: got %h expected 00090000", r_data); end
    checks++; if (pack_data !== 32'h0009_FFF9) begin errors++; $display("FAIL norelu_data: got %h expected 0009fff9", pack_data); end
    tick();
  endtask

  task automatic test_flush();
    pulse_start();
    pack_ready = 1'b1;
    send(16'd10, 10'd0);
    send(16'd20, 10'd1);
    checks++; if (pack_data !== 32'h0014_000A) begin errors++; $display("FAIL flush_w0_data: got %h expected 0014000a", pack_data); end
    send(16'd30, 10'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (pack_valid !== 1'b1) begin errors++; $display("FAIL flush_partial_valid: got %b expected 1", pack_valid); end
    checks++; if (pack_data !== 32'h0000_001E) begin errors++; $display("FAIL flush_partial_data: got %h expected 0000001e", pack_data); end
    checks++; if (pack_mask !== 2'b01) begin errors++; $display("FAIL flush_partial_mask: got %b expected 01", pack_mask); end
    checks++; if (pack_x !== 10'd2) begin errors++; $display("FAIL flush_partial_x: got %0d expected 2", pack_x); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (pack_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_valid: got %b expected 0", pack_valid); end
    checks++; if (word_count !== 32'd2) begin errors++; $display("FAIL flush_empty_count: got %0d expected 2", word_count); end
    send(16'd40, 10'd4);
    flush = 1'b1;
    send(16'd50, 10'd5);
    flush = 1'b0;
    checks++; if (pack_data !== 32'h0032_0028) begin errors++; $display("FAIL flush_complete_data: got %h expected 00320028", pack_data); end
    checks++; if (pack_mask !== 2'b11) begin errors++; $display("FAIL flush_complete_mask: got %b expected 11", pack_mask); end
    checks++; if (word_count !== 32'd3) begin errors++; $display("FAIL flush_complete_count: got %0d expected 3", word_count); end
    tick();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_word;
    pulse_start();
    pack_ready = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      send(16'(k), 10'(k - 1));
      if (k == 16) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full: got %b expected 0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (word_count !== 32'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", word_count); end
    checks++; if (pack_data !== 32'h0002_0001) begin errors++; $display("FAIL ovf_head_stable: got %h expected 00020001", pack_data); end
    pack_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      exp_word = {16'(2 * j + 2), 16'(2 * j + 1)};
      checks++; if (pack_valid !== 1'b1 || pack_data !== exp_word) begin errors++; $display("FAIL drain_word%0d: got valid=%b data=%h expected valid=1 data=%h", j, pack_valid, pack_data, exp_word); end
      tick();
    end
    checks++; if (pack_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", pack_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_full_pop();
    pulse_start();
    pack_ready = 1'b0;
    for (int k = 1; k <= 17; k++) send(16'(k), 10'(k - 1));
    pack_ready = 1'b1;
    send(16'd18, 10'd17);
    pack_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow: got %b expected 0", overflow); end
    checks++; if (word_count !== 32'd9) begin errors++; $display("FAIL fullpop_count: got %0d expected 9", word_count); end
    checks++; if (pack_data !== 32'h0004_0003) begin errors++; $display("FAIL fullpop_head: got %h expected 00040003", pack_data); end
  endtask

  task automatic test_start_mid();
    send(16'd100, 10'd0);
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 16'd200;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    checks++; if (pack_valid !== 1'b0) begin errors++; $display("FAIL start_valid: got %b expected 0", pack_valid); end
    checks++; if (pack_data !== 32'h0) begin errors++; $display("FAIL start_data: got %h expected 00000000", pack_data); end
    checks++; if (word_count !== 32'd0) begin errors++; $display("FAIL start_count: got %0d expected 0", word_count); end
    pack_ready = 1'b1;
    send(16'd5, 10'd7);
    send(16'd6, 10'd8);
    checks++; if (pack_data !== 32'h0006_0005) begin errors++; $display("FAIL start_next_word: got %h expected 00060005", pack_data); end
    checks++; if (pack_x !== 10'd7) begin errors++; $display("FAIL start_next_x: got %0d expected 7", pack_x); end
    pack_ready = 1'b0;
    send(16'd7, 10'd0);
    send(16'd8, 10'd1);
    send(16'd9, 10'd2);
    arst_n_in = 1'b0;
    #1;
    checks++; if (pack_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", pack_valid); end
    checks++; if (word_count !== 32'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", word_count); end
    tick();
    arst_n_in = 1'b1;
    pack_ready = 1'b1;
    send(16'd11, 10'd3);
    send(16'd12, 10'd4);
    checks++; if (pack_data !== 32'h000C_000B) begin errors++; $display("FAIL arst_next_word: got %h expected 000c000b", pack_data); end
    checks++; if (pack_mask !== 2'b11) begin errors++; $display("FAIL arst_next_mask: got %b expected 11", pack_mask); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_flush();
    test_overflow();
    test_full_pop();
    test_start_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/output_packer.md
# output_packer

Downstream stage of the accelerator chip's output stream. Accepts the one-element-per-cycle result stream (data plus x/y/channel coordinates, valid-only, no back-pressure) and applies optional ReLU. It packs PACK_FACTOR consecutive elements into one wide word and buffers the words in a small FIFO. The host drains the FIFO over a valid/ready interface. Overflow is flagged, never silently stalled, because the producer cannot be stopped.

## Interface
- IO_DATA_WIDTH, 16, width of one signed output element
- FEATURE_MAP_WIDTH, 1024, x range; coordinate width $clog2 of it
- FEATURE_MAP_HEIGHT, 1024, y range
- OUTPUT_NB_CHANNELS, 64, channel range
- PACK_FACTOR, 2, elements per packed word (power of two, ≥2)
- FIFO_DEPTH, 8, packed words buffered (power of two)
- RELU_EN, 0, 1 = clamp negative elements to 0 before packing
- clk  in  1  single clock, rising edge
- arst_n_in  in  1  asynchronous reset, active low
- start  in  1  synchronous clear of packer, FIFO, counters, overflow
- flush  in  1  emit a partially filled word, if any
- in_data  in  IO_DATA_WIDTH  signed element
- in_valid  in  1  element present this cycle
- in_x / in_y / in_ch  in  coordinate widths  element coordinates
- pack_data  out  PACK_FACTOR*IO_DATA_WIDTH  lane 0 in LSBs
- pack_mask  out  PACK_FACTOR  1 per valid lane
- pack_x / pack_y / pack_ch  out  coordinate widths  coordinates of lane 0
- pack_valid  out  1  FIFO head valid
- pack_ready  in  1  host accepts head
- overflow  out  1  sticky: a word was dropped
- word_count  out  32  packed words accepted into FIFO since start

## Operation
- Assembly register: lane counter 0..PACK_FACTOR-1, data lanes, lane-0 coordinates.
- in_valid: element (after ReLU if RELU_EN) written to current lane. Lane-0 coordinates captured when lane==0. Lane counter increments.
- Word complete when lane==PACK_FACTOR-1 with in_valid: push {data, mask all-ones, coords}; lane counter wraps to 0.
- flush with lane counter>0: push partial word; unfilled lanes zero, mask bits cleared. If in_valid in same cycle, the element is included first; if that completes the word, only one push occurs. flush with counter 0 and no completing input: no action.
- Push when FIFO full and no pop this cycle: word dropped, overflow set, word_count unchanged. Push while full with pop in same cycle: accepted.
- Pop when pack_valid && pack_ready.
- start: highest priority. Same-cycle in_valid/flush ignored. Lane counter, FIFO pointers, overflow, word_count cleared.
- ReLU: element < 0 → 0; otherwise unchanged. No width change.

## Timing
- Reset (arst_n_in low): pack_valid=0, pack_data=0, pack_mask=0, coordinates 0, overflow=0, word_count=0, lane counter 0. Takes effect immediately, mid-word data discarded.
- Latency: completing element at cycle N → pack_valid=1 at N+1 (FIFO previously empty, registered output).
- pack_data/mask/coords stable while pack_valid && !pack_ready.
- Sustained throughput: one element per cycle in; one word per PACK_FACTOR cycles out. No overflow if pack_ready ≥ 1/PACK_FACTOR duty.
- overflow rises the cycle after the dropped push. Cleared only by start or reset.
- word_count wraps at 2^32.

## Structure
- Package output_packer_pkg: coordinate struct typedef (x, y, ch, widths from feature-map/channel parameters) and packed-word struct typedef (data, mask, coords).
- Sub-module output_fifo: synchronous FIFO of packed-word struct, DEPTH parameter, full/empty, simultaneous push/pop legal when full or empty.

## Test plan
- Reset then 4 elements 1,2,3,4 at (x=0..3,y=0,ch=5), PACK_FACTOR=2, pack_ready=1 → words 0x0002_0001 (x=0), 0x0004_0003 (x=2), mask 2'b11, each 1 cycle after completion; word_count=2.
- RELU_EN=1: inputs -7, 9 → word 0x0009_0000.
- 3 elements 10,20,30 then flush → second word 0x0000_001E, mask 2'b01; flush with empty lane → no word.
- pack_ready=0, 18 back-to-back elements, FIFO_DEPTH=8 → 8 words held, 9th dropped, overflow=1, word_count=8; head stable; then drain 8 in order.
- FIFO full, completing element with pack_ready=1 same cycle → accepted, overflow stays 0.
- start or arst_n_in asserted mid-word (lane 1) and with FIFO non-empty → pack_valid=0 next cycle (immediately for reset); next element lands in lane 0.
